param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, bit width of each stored word (>=1).
REQ-002 SHALL provide parameter DEPTH, default 8, number of storage words (power of two, >=2).
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL provide clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide en  input  1  global enable; when low no read/write/flag-pulse occurs.
REQ-008 SHALL provide wr  input  1  write request.
REQ-009 SHALL provide rd  input  1  read request.
REQ-010 SHALL provide data_in  input  DATA_WIDTH  write data.
REQ-011 SHALL provide data_out  output  DATA_WIDTH  registered read data.
REQ-012 SHALL provide empty, full  output  1 each  occupancy == 0 / occupancy == DEPTH.
REQ-013 SHALL provide almost_empty, almost_full  output  1 each  threshold flags.
REQ-014 SHALL provide count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL provide overflow, underflow  output  1 each  one-cycle pulse on rejected write / rejected read.

Function
REQ-016 SHALL accept a write when en=1, wr=1 and (full=0 or read accepted same cycle); word stored at write pointer, pointer +1.
REQ-017 SHALL accept a read when en=1, rd=1 and empty=0; word at read pointer loaded into data_out at that edge (1-cycle latency), pointer +1.
REQ-018 SHALL not fall through: rd on empty with simultaneous wr rejects read, accepts write, pulses underflow.
REQ-019 SHALL, on simultaneous accepted read and write, leave count unchanged; when full, data_out receives the oldest word and the new word occupies the freed slot.
REQ-020 SHALL wrap both pointers from DEPTH-1 to 0 with no gap; pointers are log2(DEPTH) bits, occupancy tracked by count, never by pointer difference alone.
REQ-021 SHALL update count: +1 write-only, -1 read-only, unchanged otherwise; never exceeds DEPTH nor drops below 0.
REQ-022 SHALL derive empty, full, almost_empty (count<=AE_LEVEL), almost_full (count>=AF_LEVEL) combinationally from registered count, so flags reflect state after each edge.
REQ-023 SHALL pulse overflow for one cycle when en=1, wr=1 and write rejected; memory and pointers unchanged.
REQ-024 SHALL pulse underflow for one cycle when en=1, rd=1 and read rejected; data_out holds.
REQ-025 SHALL hold data_out between accepted reads.
REQ-026 SHALL, when en=0, hold memory, pointers, count, data_out; overflow/underflow low.

Reset
REQ-027 SHALL on rst=1 at a rising edge set pointers=0, count=0, data_out=0, overflow=0, underflow=0; rst overrides en/wr/rd.
REQ-028 SHALL after reset present empty=1, almost_empty=1, full=0, almost_full=0 (default parameters).
REQ-029 SHALL on reset mid-operation discard all contents; memory array need not be cleared; no stale word is readable.

Verification
REQ-030 SHALL cover fill: reset, 8 writes 0x11..0x88 -> count 1..8, almost_full at count 6, full at 8; 9th write -> overflow pulse, count stays 8.
REQ-031 SHALL cover drain: from full, 8 reads -> data_out 0x11..0x88, each one cycle after rd; 9th read -> underflow pulse, data_out holds 0x88, empty=1.
REQ-032 SHALL cover wrap: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> data in order, pointers wrap past 7, no loss.
REQ-033 SHALL cover simultaneous: full FIFO, rd=wr=1 with data_in=0xFF -> data_out=oldest word, count 8, no overflow; on empty, rd=wr=1 -> underflow, count 1.
REQ-034 SHALL cover en gating and reset: en=0 with wr/rd toggling -> no state change; rst at count 4 -> count 0, empty=1, data_out 0, next read underflows.
REQ-035 SHALL be re-run with DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=1 with identical pass criteria scaled.

Source files
------------

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - request/data/status bundle between a FIFO user and param_fifo
// Signals:
//   en, wr, rd, data_in             : user -> FIFO (enable, write/read requests, write data)
//   data_out                        : FIFO -> user, registered read data
//   empty, full                     : FIFO -> user, occupancy == 0 / == DEPTH
//   almost_empty, almost_full       : FIFO -> user, threshold flags
//   count                           : FIFO -> user, occupancy 0..DEPTH
//   overflow, underflow             : FIFO -> user, one-cycle rejected-request pulses
// Modports: master = FIFO user, slave = FIFO.
interface param_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic                     en;
  logic                     wr;
  logic                     rd;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     empty;
  logic                     full;
  logic                     almost_empty;
  logic                     almost_full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output en, wr, rd, data_in,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  en, wr, rd, data_in,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - single-clock synchronous FIFO with registered output and threshold flags
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (overrides en/wr/rd)
//   bus : param_fifo_if.slave (en/wr/rd/data_in in; data_out, flags, count, overflow/underflow out)
module param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  always_comb begin
    // A read never falls through: it needs a stored word before this edge.
    rd_acc = bus.en & bus.rd & (count_q != '0);
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    wr_acc = bus.en & bus.wr & ((count_q != DEPTH_C) | rd_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = bus.en & bus.wr & ~wr_acc;
    underflow_d = bus.en & bus.rd & ~rd_acc;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared on reset; count=0 makes old words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.almost_full  = (count_q >= AF_C);
endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - scoreboard bench for param_fifo against a queue reference model
module tb_param_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AF    = DEPTH - 2,
  parameter int AE    = 2
);
  typedef struct {
    logic [DW-1:0] dout;
    int            cnt;
    bit            ovf;
    bit            udf;
  } exp_t;

  logic clk;
  logic rst;
  param_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  param_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock of stimulus; the model decides the outcome from the queue contents alone.
  task automatic step(input bit r, input bit e, input bit w, input bit rd_i, input logic [DW-1:0] d);
    exp_t x;
    bit rd_ok, wr_ok;
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.wr = w;
    bus.rd = rd_i;
    bus.data_in = d;
    if (r) begin
      model_q.delete();
      model_dout = '0;
      x.ovf = 0;
      x.udf = 0;
    end else begin
      rd_ok = e && rd_i && (model_q.size() > 0);
      wr_ok = e && w && ((model_q.size() < DEPTH) || rd_ok);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      x.ovf = e && w && !wr_ok;
      x.udf = e && rd_i && !rd_ok;
    end
    x.dout = model_dout;
    x.cnt  = model_q.size();
    @(posedge clk);
    exp_q.push_back(x);
  endtask

  task automatic do_wr(input logic [DW-1:0] d);
    step(0, 1, 1, 0, d);
  endtask

  task automatic do_rd();
    step(0, 1, 0, 1, '0);
  endtask

  // Monitor: every cycle after an edge with a pending expectation, compare all outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("data_out",     64'(bus.data_out),     64'(x.dout));
        chk("count",        64'(bus.count),        64'(x.cnt));
        chk("overflow",     64'(bus.overflow),     64'(x.ovf));
        chk("underflow",    64'(bus.underflow),    64'(x.udf));
        chk("empty",        64'(bus.empty),        64'(x.cnt == 0));
        chk("full",         64'(bus.full),         64'(x.cnt == DEPTH));
        chk("almost_empty", 64'(bus.almost_empty), 64'(x.cnt <= AE));
        chk("almost_full",  64'(bus.almost_full),  64'(x.cnt >= AF));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.data_in = '0;

    // Reset, then fill with 0x11, 0x22, ... and one rejected extra write.
    step(1, 1, 1, 1, '1);
    for (int i = 0; i < DEPTH; i++) do_wr(DW'((i + 1) * 'h11));
    do_wr(DW'('h99));

    // Drain in order, then one rejected read with data_out holding.
    for (int i = 0; i <= DEPTH; i++) do_rd();

    // Wrap: 5 in/out, then a full lap of DEPTH words.
    for (int i = 0; i < 5; i++) do_wr(DW'('h50 + i));
    for (int i = 0; i < 5; i++) do_rd();
    for (int i = 0; i < DEPTH; i++) do_wr(DW'('hA0 + i));
    for (int i = 0; i < DEPTH; i++) do_rd();

    // Simultaneous read/write on a full FIFO, then on an empty one.
    for (int i = 0; i < DEPTH; i++) do_wr(DW'('hC0 + i));
    step(0, 1, 1, 1, DW'('hFF));
    for (int i = 0; i < DEPTH; i++) do_rd();
    step(0, 1, 1, 1, DW'('h3C));
    do_rd();

    // Enable gating: requests toggle while en is low.
    do_wr(DW'('h77));
    for (int i = 0; i < 10; i++) step(0, 0, i[0], ~i[0], DW'($urandom));

    // Reset at count 4 then a read must underflow with data_out cleared.
    for (int i = 0; i < 3; i++) do_wr(DW'('hE0 + i));
    step(1, 1, 1, 1, DW'('h12));
    do_rd();

    // Randomised traffic with occasional resets and enable drops.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, DW'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
